// File: rtl/rr_decoder_sel_pkg.sv
// Shared constants and types for the round-robin decoder-select arbiter
// and the 3-to-8 decoder stage it feeds.
package rr_decoder_sel_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned N_REQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Next round-robin start position; wraps 7 -> 0 through the 3-bit width.
  function automatic logic [SEL_W-1:0] idx_inc(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_decoder_sel_if.sv
// Request/select bundle between requesters, the arbiter and the decoder.
// The owner-release strobe is owner_release because "release" is reserved.
interface rr_decoder_sel_if;
  import rr_decoder_sel_pkg::*;

  logic [N_REQ-1:0] req;
  logic             owner_release;
  logic [SEL_W-1:0] sel;
  logic             sel_en;
  logic             timeout;

  modport master (
    output req,
    output owner_release,
    input  sel,
    input  sel_en,
    input  timeout
  );

  modport slave (
    input  req,
    input  owner_release,
    output sel,
    output sel_en,
    output timeout
  );

endinterface

// File: rtl/rr_decoder_sel_pick8.sv
// Combinational round-robin pick: first set request at or after ptr (mod 8).
module rr_pick8
  import rr_decoder_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);

  logic [N_REQ-1:0] rotated;
  logic [SEL_W-1:0] offset;

  // Rotate so bit 0 is the requester at ptr; index arithmetic wraps at 3 bits.
  always_comb begin
    rotated = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rotated[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Scan high to low so the lowest set bit is the one left in offset.
  always_comb begin
    offset = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rotated[i-1]) begin
        offset = SEL_W'(i - 1);
      end
    end
  end

  assign winner  = offset + ptr;
  assign any_req = |req;

endmodule

// File: rtl/rr_decoder_sel.sv
// Round-robin arbiter over 8 requesters driving a 3-to-8 decoder's A2..A0/EN,
// with rotating priority, a bounded hold per grant and a dead cycle between owners.
module rr_decoder_sel
  import rr_decoder_sel_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  rr_decoder_sel_if.slave   bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic [SEL_W-1:0] winner;
  logic             any_req;

  rr_pick8 u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Release (or the owner dropping its request) outranks hold expiry, so a
  // coincident release never produces a timeout pulse.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = winner;
          ptr_d   = idx_inc(winner);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (bus.owner_release || !bus.req[sel_q]) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel     = sel_q;
  assign bus.sel_en  = (state_q == GRANT);
  assign bus.timeout = timeout_q;

  a_sel_stable : assert property (@(posedge clk) disable iff (rst)
    bus.sel_en |=> (!bus.sel_en || $stable(bus.sel)));

  a_timeout_idle : assert property (@(posedge clk)
    bus.timeout |-> !bus.sel_en);

endmodule
